// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage and its neighbours.
// Holds the datapath width, the register count, the shift-control
// encodings shared with the shifter, and the fetch FSM state type.
package operand_fetch_pkg;

    localparam int REG_SIZE = 16;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = $clog2(NUM_REGS);

    // Shift control encodings carried alongside the B operand.
    localparam logic [1:0] SHIFT_NO         = 2'b00;
    localparam logic [1:0] SHIFT_LEFT_ZERO  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT_ZERO = 2'b10;
    localparam logic [1:0] SHIFT_RIGHT_COPY = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_A = 2'd1,
        FETCH_B = 2'd2,
        OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle for the operand fetch stage.
//   request side  : req_valid, req_ready, rd_a_num, rd_b_num, shift_in
//   writeback     : wb_en, wb_num, wb_data
//   operand side  : out_valid, out_ready, a_out, b_out, shift_out
// Handshake rule (both request and operand sides): a transfer happens on a
// rising clock edge where valid and ready are both 1; the producer keeps its
// payload stable while valid=1 and ready=0.
// slave  : the operand fetch stage itself.
// master : the environment (issue logic, writeback, downstream consumer).
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [IDX_W-1:0]    rd_a_num;
    logic [IDX_W-1:0]    rd_b_num;
    logic [1:0]          shift_in;

    logic                wb_en;
    logic [IDX_W-1:0]    wb_num;
    logic [REG_SIZE-1:0] wb_data;

    logic                out_valid;
    logic                out_ready;
    logic [REG_SIZE-1:0] a_out;
    logic [REG_SIZE-1:0] b_out;
    logic [1:0]          shift_out;

    modport slave (
        input  req_valid, rd_a_num, rd_b_num, shift_in,
        input  wb_en, wb_num, wb_data,
        input  out_ready,
        output req_ready, out_valid, a_out, b_out, shift_out
    );

    modport master (
        output req_valid, rd_a_num, rd_b_num, shift_in,
        output wb_en, wb_num, wb_data,
        output out_ready,
        input  req_ready, out_valid, a_out, b_out, shift_out
    );

endinterface

// File: rtl/operand_fetch_regfile.sv
// Register file: DEPTH x WIDTH, one synchronous write port, one
// combinational read port, asynchronous active-low clear of every entry.
// Ports:
//   clk, rst_n        clock, async active-low clear
//   wr_en/wr_idx/wr_data  write port (takes effect at the rising edge)
//   rd_idx/rd_data    combinational read port (pre-write contents)
module operand_fetch_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage. On an accepted request it reads source A, then
// source B, through the single register file read port in consecutive
// cycles, and presents the latched pair plus shift control downstream.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         operand_fetch_if.slave (request, writeback, operand sides)
//   state       current FSM state, for observation only
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_if.slave       bus,
    output state_t               state
);

    state_t              state_q;
    state_t              state_d;

    logic [IDX_W-1:0]    a_num_q;
    logic [IDX_W-1:0]    b_num_q;
    logic [1:0]          shift_q;
    logic [REG_SIZE-1:0] a_q;
    logic [REG_SIZE-1:0] b_q;

    logic [IDX_W-1:0]    rd_idx;
    logic [REG_SIZE-1:0] rf_data;
    logic [REG_SIZE-1:0] rd_value;

    operand_fetch_regfile #(
        .WIDTH (REG_SIZE),
        .DEPTH (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wb_en),
        .wr_idx  (bus.wb_num),
        .wr_data (bus.wb_data),
        .rd_idx  (rd_idx),
        .rd_data (rf_data)
    );

    // The read port serves A in FETCH_A and B in FETCH_B; outside those
    // states the value is unused.
    assign rd_idx = (state_q == FETCH_B) ? b_num_q : a_num_q;

    // A write landing on the register being read this cycle is forwarded,
    // since the register file only shows it after the edge.
    assign rd_value = (bus.wb_en && (bus.wb_num == rd_idx)) ? bus.wb_data : rf_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = FETCH_A;
            FETCH_A: state_d = FETCH_B;
            FETCH_B: state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Indices and shift control are captured only at acceptance; operands
    // are captured once and then held, so later writes cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_num_q <= '0;
            b_num_q <= '0;
            shift_q <= SHIFT_NO;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_num_q <= bus.rd_a_num;
                        b_num_q <= bus.rd_b_num;
                        shift_q <= bus.shift_in;
                    end
                end
                FETCH_A: a_q <= rd_value;
                FETCH_B: b_q <= rd_value;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.shift_out = shift_q;
    assign state         = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dut_state;

    int vectors     = 0;
    int miscompares = 0;

    // Expected operand transfers: {a, b, shift}.
    logic [33:0] exp_q[$];

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (dut_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] num, input logic [15:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_num  = num;
        bus.wb_data = data;
        tick();
        bus.wb_en   = 1'b0;
    endtask

    // Presents a request for one cycle; caller is in IDLE, so it is accepted.
    task automatic request(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh);
        bus.req_valid = 1'b1;
        bus.rd_a_num  = a;
        bus.rd_b_num  = b;
        bus.shift_in  = sh;
        tick();
        bus.req_valid = 1'b0;
        bus.rd_a_num  = 3'd7;
        bus.rd_b_num  = 3'd7;
        bus.shift_in  = 2'b00;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sh);
        exp_q.push_back({a, b, sh});
    endtask

    task automatic check_out(input string tag);
        logic [33:0] e;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_a"},     32'(bus.a_out),     32'(e[33:18]));
            check({tag, "_b"},     32'(bus.b_out),     32'(e[17:2]));
            check({tag, "_shift"}, 32'(bus.shift_out), 32'(e[1:0]));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rd_a_num  = '0;
        bus.rd_b_num  = '0;
        bus.shift_in  = '0;
        bus.wb_en     = 1'b0;
        bus.wb_num    = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #23;
        check("rst_state",     32'(dut_state),     32'(IDLE));
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_a",         32'(bus.a_out),     32'd0);
        check("rst_b",         32'(bus.b_out),     32'd0);
        check("rst_shift",     32'(bus.shift_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic fetch: R1=0x1234, R2=0xF00F, shift=11
        wb_write(3'd1, 16'h1234);
        wb_write(3'd2, 16'hF00F);
        expect_op(16'h1234, 16'hF00F, SHIFT_RIGHT_COPY);
        request(3'd1, 3'd2, SHIFT_RIGHT_COPY);                 // E0
        check("e0_state",     32'(dut_state),     32'(FETCH_A));
        check("e0_req_ready", 32'(bus.req_ready), 32'd0);
        check("e0_out_valid", 32'(bus.out_valid), 32'd0);
        tick();                                                // E1
        check("e1_a",         32'(bus.a_out),     32'h1234);
        check("e1_out_valid", 32'(bus.out_valid), 32'd0);
        tick();                                                // E2
        check_out("basic");
        tick();                                                // E3
        check("e3_req_ready", 32'(bus.req_ready), 32'd1);
        check("e3_out_valid", 32'(bus.out_valid), 32'd0);

        // Bypass into B during FETCH_B: R4 <- 0xBEEF
        expect_op(16'h0000, 16'hBEEF, SHIFT_NO);
        request(3'd3, 3'd4, SHIFT_NO);
        tick();                                                // now FETCH_B
        bus.wb_en = 1'b1; bus.wb_num = 3'd4; bus.wb_data = 16'hBEEF;
        tick();
        bus.wb_en = 1'b0;
        check_out("bypass_b");
        tick();

        // Post-latch write: R3 <- 0x5555 during FETCH_B, A keeps old R3
        expect_op(16'h0000, 16'h1234, SHIFT_LEFT_ZERO);
        request(3'd3, 3'd1, SHIFT_LEFT_ZERO);
        tick();
        bus.wb_en = 1'b1; bus.wb_num = 3'd3; bus.wb_data = 16'h5555;
        tick();
        bus.wb_en = 1'b0;
        check_out("post_latch");
        tick();

        // Following request reads the new R3 and the bypassed R4
        expect_op(16'h5555, 16'hBEEF, SHIFT_RIGHT_ZERO);
        request(3'd3, 3'd4, SHIFT_RIGHT_ZERO);
        tick();
        tick();
        check_out("reread");
        tick();

        // Same register for A and B, bypass during FETCH_A: R2 <- 0xA5A5
        expect_op(16'hA5A5, 16'hA5A5, SHIFT_NO);
        request(3'd2, 3'd2, SHIFT_NO);
        bus.wb_en = 1'b1; bus.wb_num = 3'd2; bus.wb_data = 16'hA5A5;
        tick();                                                // FETCH_A edge
        bus.wb_en = 1'b0;
        tick();
        check_out("same_reg");
        tick();

        // Backpressure for 5 cycles
        bus.out_ready = 1'b0;
        expect_op(16'h1234, 16'hA5A5, SHIFT_LEFT_ZERO);
        request(3'd1, 3'd2, SHIFT_LEFT_ZERO);
        tick();
        tick();                                                // OUT
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = i[0];
            bus.rd_a_num  = 3'd5;
            bus.wb_en     = 1'b1;
            bus.wb_num    = 3'd1;
            bus.wb_data   = 16'h1000 + 16'(i);
            tick();
            check("bp_state",     32'(dut_state),     32'(OUT));
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_a",         32'(bus.a_out),     32'h1234);
            check("bp_b",         32'(bus.b_out),     32'hA5A5);
        end
        bus.req_valid = 1'b0;
        bus.wb_en     = 1'b0;
        check_out("bp_release");
        bus.out_ready = 1'b1;
        tick();
        check("bp_idle",       32'(dut_state),     32'(IDLE));
        check("bp_out_valid0", 32'(bus.out_valid), 32'd0);
        tick();
        check("bp_no_second",  32'(dut_state),     32'(IDLE));

        // R1 holds the last backpressure write
        expect_op(16'h1004, 16'hA5A5, SHIFT_RIGHT_COPY);
        request(3'd1, 3'd2, SHIFT_RIGHT_COPY);
        tick();
        tick();
        check_out("bp_written");
        tick();

        // Reset during FETCH_B
        request(3'd1, 3'd2, SHIFT_RIGHT_COPY);
        tick();                                                // FETCH_B
        check("mid_pre_state", 32'(dut_state), 32'(FETCH_B));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_state",     32'(dut_state),     32'(IDLE));
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_a",         32'(bus.a_out),     32'd0);
        check("mid_b",         32'(bus.b_out),     32'd0);
        check("mid_shift",     32'(bus.shift_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_no_output", 32'(bus.out_valid), 32'd0);

        // Registers read as zero after reset
        expect_op(16'h0000, 16'h0000, SHIFT_NO);
        request(3'd1, 3'd2, SHIFT_NO);
        tick();
        tick();
        check_out("zero_12");
        tick();
        expect_op(16'h0000, 16'h0000, SHIFT_LEFT_ZERO);
        request(3'd4, 3'd3, SHIFT_LEFT_ZERO);
        tick();
        tick();
        check_out("zero_43");
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
